// File: rtl/time_pkg.sv
// Shared time-of-day constants: FSM encodings, field layout and field limits.
// Also imported by the display controller so both agree on the out_time packing.
package time_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_SET_HOUR = 2'd1,
        ST_SET_MIN  = 2'd2,
        ST_SET_SEC  = 2'd3
    } state_e;

    localparam int HOUR_W    = 5;
    localparam int MIN_W     = 6;
    localparam int SEC_W     = 6;
    localparam int TENTH_W   = 4;
    localparam int TIME_W    = HOUR_W + MIN_W + SEC_W + TENTH_W;
    localparam int TENTH_LSB = 0;
    localparam int SEC_LSB   = TENTH_LSB + TENTH_W;
    localparam int MIN_LSB   = SEC_LSB + SEC_W;
    localparam int HOUR_LSB  = MIN_LSB + MIN_W;

    localparam logic [4:0] HOUR_MAX  = 5'd23;
    localparam logic [5:0] MIN_MAX   = 6'd59;
    localparam logic [5:0] SEC_MAX   = 6'd59;
    localparam logic [3:0] TENTH_MAX = 4'd9;

    function automatic logic [2:0] flash_of(input state_e s);
        case (s)
            ST_RUN:      flash_of = 3'b000;
            ST_SET_HOUR: flash_of = 3'b100;
            ST_SET_MIN:  flash_of = 3'b010;
            ST_SET_SEC:  flash_of = 3'b001;
            default:     flash_of = 3'b000;
        endcase
    endfunction

    function automatic logic [5:0] wrap_inc(input logic [5:0] v, input logic [5:0] max);
        wrap_inc = (v >= max) ? 6'd0 : v + 6'd1;
    endfunction

    function automatic logic [5:0] wrap_dec(input logic [5:0] v, input logic [5:0] max);
        wrap_dec = (v == 6'd0 || v > max) ? max : v - 6'd1;
    endfunction

endpackage

// File: rtl/time_keeper_tick_gen.sv
// Prescaler producing a one-cycle tick every TICKS_PER_TENTH enabled cycles.
// Holds its count while disabled; clear restarts a full interval.
module tick_gen #(
    parameter int TICKS_PER_TENTH = 5000000
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic clear,
    output logic tick
);

    localparam int CW = (TICKS_PER_TENTH > 1) ? $clog2(TICKS_PER_TENTH) : 1;
    localparam logic [CW-1:0] TERM = CW'(TICKS_PER_TENTH - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    assign tick = enable && (count_q == TERM);

    // Next prescaler count
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (tick) begin
            count_d = '0;
        end else if (enable) begin
            count_d = count_q + CW'(1);
        end else begin
            count_d = count_q;
        end
    end

    // Prescaler register
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/time_keeper.sv
// Time-of-day counter with a run/set FSM; buttons edit one field at a time
// while the clock is frozen, and leaving the seconds edit restarts at x.0.
module time_keeper
    import time_pkg::*;
#(
    parameter int TICKS_PER_TENTH = 5000000
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          btn_mode,
    input  logic          btn_inc,
    input  logic          btn_dec,
    output logic [20:0]   out_time,
    output logic [2:0]    flash,
    output logic          display_mode
);

    state_e state_q, state_d;
    logic [HOUR_W-1:0]  hour_q,  hour_d;
    logic [MIN_W-1:0]   min_q,   min_d;
    logic [SEC_W-1:0]   sec_q,   sec_d;
    logic [TENTH_W-1:0] tenth_q, tenth_d;
    logic [2:0]         flash_q;
    logic               disp_q;
    logic               tick_s;
    logic               clear_s;
    logic               edit_s;

    tick_gen #(.TICKS_PER_TENTH(TICKS_PER_TENTH)) u_tick_gen (
        .clk    (clk),
        .reset  (reset),
        .enable (state_q == ST_RUN),
        .clear  (clear_s),
        .tick   (tick_s)
    );

    // Simultaneous inc and dec cancel out
    assign edit_s = btn_inc ^ btn_dec;

    // FSM next state and field updates
    always_comb begin
        state_d = state_q;
        hour_d  = hour_q;
        min_d   = min_q;
        sec_d   = sec_q;
        tenth_d = tenth_q;
        clear_s = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (tick_s) begin
                    if (tenth_q >= TENTH_MAX) begin
                        tenth_d = 4'd0;
                        if (sec_q >= SEC_MAX) begin
                            sec_d = 6'd0;
                            if (min_q >= MIN_MAX) begin
                                min_d  = 6'd0;
                                hour_d = (hour_q >= HOUR_MAX) ? 5'd0 : hour_q + 5'd1;
                            end else begin
                                min_d = min_q + 6'd1;
                            end
                        end else begin
                            sec_d = sec_q + 6'd1;
                        end
                    end else begin
                        tenth_d = tenth_q + 4'd1;
                    end
                end else begin
                    tenth_d = tenth_q;
                end
                if (btn_mode) begin
                    state_d = ST_SET_HOUR;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_SET_HOUR: begin
                if (btn_mode) begin
                    state_d = ST_SET_MIN;
                end else if (edit_s) begin
                    hour_d = btn_inc ? 5'(wrap_inc({1'b0, hour_q}, {1'b0, HOUR_MAX}))
                                     : 5'(wrap_dec({1'b0, hour_q}, {1'b0, HOUR_MAX}));
                end else begin
                    state_d = ST_SET_HOUR;
                end
            end
            ST_SET_MIN: begin
                if (btn_mode) begin
                    state_d = ST_SET_SEC;
                end else if (edit_s) begin
                    min_d = btn_inc ? wrap_inc(min_q, MIN_MAX) : wrap_dec(min_q, MIN_MAX);
                end else begin
                    state_d = ST_SET_MIN;
                end
            end
            ST_SET_SEC: begin
                if (btn_mode) begin
                    state_d = ST_RUN;
                    tenth_d = 4'd0;
                    clear_s = 1'b1;
                end else if (edit_s) begin
                    sec_d = btn_inc ? wrap_inc(sec_q, SEC_MAX) : wrap_dec(sec_q, SEC_MAX);
                end else begin
                    state_d = ST_SET_SEC;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // State, field and indicator registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_RUN;
            hour_q  <= 5'd0;
            min_q   <= 6'd0;
            sec_q   <= 6'd0;
            tenth_q <= 4'd0;
            flash_q <= 3'b000;
            disp_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            hour_q  <= hour_d;
            min_q   <= min_d;
            sec_q   <= sec_d;
            tenth_q <= tenth_d;
            flash_q <= flash_of(state_d);
            disp_q  <= (state_d != ST_RUN);
        end
    end

    assign out_time     = {hour_q, min_q, sec_q, tenth_q};
    assign flash        = flash_q;
    assign display_mode = disp_q;

endmodule

// File: tb/tb_time_keeper.sv
// Directed bench for time_keeper: stimulus pushes hand-computed expectations
// into a scoreboard queue that a negedge monitor drains and compares.
module tb_time_keeper;

    logic        clk = 1'b0;
    logic        reset;
    logic        btn_mode, btn_inc, btn_dec;
    logic [20:0] out_time;
    logic [2:0]  flash;
    logic        display_mode;

    typedef struct packed {
        logic [20:0] t;
        logic [2:0]  f;
        logic        d;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    checks   = 0;
    int    failures = 0;

    time_keeper #(.TICKS_PER_TENTH(2)) dut (
        .clk          (clk),
        .reset        (reset),
        .btn_mode     (btn_mode),
        .btn_inc      (btn_inc),
        .btn_dec      (btn_dec),
        .out_time     (out_time),
        .flash        (flash),
        .display_mode (display_mode)
    );

    always #5 clk = ~clk;

    function automatic logic [20:0] tm(input int h, input int m, input int s, input int t);
        tm = {5'(h), 6'(m), 6'(s), 4'(t)};
    endfunction

    // Monitor: compare every pending expectation against the settled outputs
    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            exp_t  e;
            string n;
            e = exp_q.pop_front();
            n = name_q.pop_front();
            checks++;
            if (out_time !== e.t || flash !== e.f || display_mode !== e.d) begin
                failures++;
                $display("FAIL %s: got time=%0d:%0d:%0d.%0d flash=%b disp=%b, want time=%0d:%0d:%0d.%0d flash=%b disp=%b",
                         n, out_time[20:16], out_time[15:10], out_time[9:4], out_time[3:0], flash, display_mode,
                         e.t[20:16], e.t[15:10], e.t[9:4], e.t[3:0], e.f, e.d);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string n, input logic [20:0] t, input logic [2:0] f, input logic d);
        exp_t e;
        e.t = t;
        e.f = f;
        e.d = d;
        exp_q.push_back(e);
        name_q.push_back(n);
    endtask

    task automatic press(input logic m, input logic i, input logic d);
        btn_mode = m;
        btn_inc  = i;
        btn_dec  = d;
        step(1);
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
        btn_dec  = 1'b0;
    endtask

    task automatic press_n(input logic i, input logic d, input int n);
        for (int k = 0; k < n; k++) press(1'b0, i, d);
    endtask

    initial begin
        reset = 1'b1;
        btn_mode = 1'b0;
        btn_inc = 1'b0;
        btn_dec = 1'b0;
        step(3);
        expect_out("reset_state", tm(0, 0, 0, 0), 3'b000, 1'b0);
        reset = 1'b0;

        // Free run: one tick every 2 cycles
        step(1);  expect_out("run_no_tick_yet", tm(0, 0, 0, 0), 3'b000, 1'b0);
        step(1);  expect_out("run_first_tick", tm(0, 0, 0, 1), 3'b000, 1'b0);
        step(18); expect_out("run_20_cycles", tm(0, 0, 1, 0), 3'b000, 1'b0);

        // Editing
        press(1'b1, 1'b0, 1'b0); expect_out("enter_set_hour", tm(0, 0, 1, 0), 3'b100, 1'b1);
        press(1'b0, 1'b0, 1'b1); expect_out("hour_dec_wrap", tm(23, 0, 1, 0), 3'b100, 1'b1);
        press(1'b1, 1'b0, 1'b0); expect_out("enter_set_min", tm(23, 0, 1, 0), 3'b010, 1'b1);
        press(1'b0, 1'b1, 1'b0); expect_out("min_inc", tm(23, 1, 1, 0), 3'b010, 1'b1);
        press_n(1'b1, 1'b0, 59); expect_out("min_inc60_wrap", tm(23, 0, 1, 0), 3'b010, 1'b1);
        press_n(1'b1, 1'b0, 5);  expect_out("min_inc5", tm(23, 5, 1, 0), 3'b010, 1'b1);

        // Simultaneous inputs
        press(1'b0, 1'b1, 1'b1); expect_out("inc_dec_same_cycle", tm(23, 5, 1, 0), 3'b010, 1'b1);
        press(1'b1, 1'b1, 1'b0); expect_out("mode_priority", tm(23, 5, 1, 0), 3'b001, 1'b1);
        press_n(1'b0, 1'b1, 2);  expect_out("sec_dec_wrap", tm(23, 5, 59, 0), 3'b001, 1'b1);
        press(1'b0, 1'b1, 1'b0); expect_out("sec_inc_wrap", tm(23, 5, 0, 0), 3'b001, 1'b1);
        press(1'b0, 1'b0, 1'b1); expect_out("sec_dec_back", tm(23, 5, 59, 0), 3'b001, 1'b1);

        // Build 23:59:59 and roll over
        press(1'b1, 1'b0, 1'b0);
        press(1'b1, 1'b0, 1'b0);
        press(1'b1, 1'b0, 1'b0);
        press_n(1'b0, 1'b1, 6);  expect_out("min_dec_wrap", tm(23, 59, 59, 0), 3'b010, 1'b1);
        press(1'b1, 1'b0, 1'b0);
        press(1'b1, 1'b0, 1'b0); expect_out("resume_235959", tm(23, 59, 59, 0), 3'b000, 1'b0);
        step(19); expect_out("pre_rollover", tm(23, 59, 59, 9), 3'b000, 1'b0);
        step(1);  expect_out("rollover", tm(0, 0, 0, 0), 3'b000, 1'b0);

        // inc/dec ignored in RUN
        press(1'b0, 1'b1, 1'b0); expect_out("run_ignore_inc", tm(0, 0, 0, 0), 3'b000, 1'b0);
        press(1'b0, 1'b0, 1'b1); expect_out("run_ignore_dec", tm(0, 0, 0, 1), 3'b000, 1'b0);

        // Reset mid-edit at 12:34:56
        press(1'b1, 1'b0, 1'b0); press_n(1'b1, 1'b0, 12);
        press(1'b1, 1'b0, 1'b0); press_n(1'b1, 1'b0, 34);
        press(1'b1, 1'b0, 1'b0); press_n(1'b1, 1'b0, 56);
        expect_out("set_123456", tm(12, 34, 56, 1), 3'b001, 1'b1);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        expect_out("reset_mid_edit", tm(0, 0, 0, 0), 3'b000, 1'b0);
        step(1); expect_out("post_reset_no_tick", tm(0, 0, 0, 0), 3'b000, 1'b0);
        step(1); expect_out("post_reset_tick", tm(0, 0, 0, 1), 3'b000, 1'b0);

        // Resume from 10:20:30 with nonzero tenth
        press(1'b1, 1'b0, 1'b0); press_n(1'b1, 1'b0, 10);
        press(1'b1, 1'b0, 1'b0); press_n(1'b1, 1'b0, 20);
        press(1'b1, 1'b0, 1'b0); press_n(1'b1, 1'b0, 30);
        expect_out("set_102030", tm(10, 20, 30, 1), 3'b001, 1'b1);
        press(1'b1, 1'b0, 1'b0); expect_out("resume_tenth_clear", tm(10, 20, 30, 0), 3'b000, 1'b0);
        step(1); expect_out("resume_full_interval", tm(10, 20, 30, 0), 3'b000, 1'b0);
        step(1); expect_out("resume_first_tick", tm(10, 20, 30, 1), 3'b000, 1'b0);

        // Drain the scoreboard with a bounded wait
        for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clk);
        if (exp_q.size() > 0) begin
            failures++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
